// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter and sequencer for a single-port memory
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   ifu_req_* / ifu_resp_*           IFU read-only request and response handshakes
//   lsu_req_* / lsu_resp_*           LSU read/write request and response handshakes
//   mem_*                            single-port memory request outputs, mem_rdata input
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_resp_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [7:0]        lsu_req_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_resp_rdata,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_owner;
    logic               r_last;
    logic               r_wen;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [7:0]         r_wmask;
    logic               w_grant_ifu;
    logic               w_grant_lsu;
    logic               w_resp_done;
    logic               w_access;
    logic               w_resp;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        w_resp_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the port that did not win last time gets the grant.
                w_grant_ifu = ifu_req_valid && (!lsu_req_valid || r_last == OWN_LSU);
                w_grant_lsu = lsu_req_valid && (!ifu_req_valid || r_last == OWN_IFU);
                if (w_grant_ifu || w_grant_lsu) begin
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_done = (r_owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;
                if (w_resp_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_owner <= OWN_IFU;
            r_last  <= OWN_LSU;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_ifu) begin
                r_owner <= OWN_IFU;
                r_last  <= OWN_IFU;
                r_addr  <= ifu_req_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end else if (w_grant_lsu) begin
                r_owner <= OWN_LSU;
                r_last  <= OWN_LSU;
                r_addr  <= lsu_req_addr;
                r_wen   <= lsu_req_wen;
                r_wdata <= lsu_req_wdata;
                r_wmask <= lsu_req_wmask;
            end
            // Writes return zero as their completion data.
            if (r_state == S_ACCESS) begin
                r_rdata <= r_wen ? '0 : mem_rdata;
            end
        end
    end

    // Memory outputs decode from state alone so an async reset drops them at once.
    assign w_access  = (r_state == S_ACCESS);
    assign w_resp    = (r_state == S_RESP);

    assign ifu_req_ready  = w_grant_ifu;
    assign lsu_req_ready  = w_grant_lsu;

    assign mem_valid = w_access;
    assign mem_wen   = w_access && r_wen;
    assign mem_raddr = w_access ? r_addr  : '0;
    assign mem_waddr = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;
    assign mem_wmask = w_access ? r_wmask : '0;

    assign ifu_resp_valid = w_resp && (r_owner == OWN_IFU);
    assign lsu_resp_valid = w_resp && (r_owner == OWN_LSU);
    assign ifu_resp_rdata = ifu_resp_valid ? r_rdata : '0;
    assign lsu_resp_rdata = lsu_resp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic [7:0]  lsu_req_wmask;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_checks = 0;
    int n_errors = 0;

    logic        exp_grant [$];
    logic [31:0] exp_ifu   [$];
    logic [31:0] exp_lsu   [$];

    // slot 0: 0x80000000, slot 1: 0x80001000, slot 2: 0x80002000
    logic [31:0] mem [0:3] = '{32'h00000413, 32'h11111111, 32'h12345678, 32'h0};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
        .mem_valid(mem_valid), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_valid ? mem[mem_raddr[13:12]] : 32'h0;

    always @(posedge clk) begin
        if (mem_valid && mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem[mem_waddr[13:12]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: grants and response handshakes are matched against the queues.
    always @(negedge clk) begin
        if (resetn) begin
            if (ifu_req_ready && lsu_req_ready) check("dual_grant", 64'd1, 64'd0);
            if (ifu_req_ready || lsu_req_ready) begin
                if (exp_grant.size() == 0) check("unexpected_grant", {63'd0, lsu_req_ready}, 64'hFFFF);
                else check("grant_owner", {63'd0, lsu_req_ready}, {63'd0, exp_grant.pop_front()});
            end
            if (ifu_resp_valid && ifu_resp_ready) begin
                if (exp_ifu.size() == 0) check("unexpected_ifu_resp", {32'd0, ifu_resp_rdata}, 64'hFFFF);
                else check("ifu_rdata", {32'd0, ifu_resp_rdata}, {32'd0, exp_ifu.pop_front()});
            end
            if (lsu_resp_valid && lsu_resp_ready) begin
                if (exp_lsu.size() == 0) check("unexpected_lsu_resp", {32'd0, lsu_resp_rdata}, 64'hFFFF);
                else check("lsu_rdata", {32'd0, lsu_resp_rdata}, {32'd0, exp_lsu.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_resp_ready = 0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
        check("rst_resp", {30'd0, ifu_resp_valid, lsu_resp_valid, ifu_resp_rdata | lsu_resp_rdata}, 64'd0);
        check("rst_mem", {mem_valid, mem_wen, mem_wmask, mem_raddr | mem_waddr | mem_wdata}, 64'd0);

        // IFU read alone
        step();
        resetn = 1'b1;
        ifu_req_valid = 1; ifu_req_addr = 32'h80000000; ifu_resp_ready = 1;
        exp_grant.push_back(1'b0); exp_ifu.push_back(32'h00000413);
        @(negedge clk);
        check("ifu_c0_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        step();
        ifu_req_valid = 0;
        @(negedge clk);
        check("ifu_c1_mem", {30'd0, mem_valid, mem_wen, mem_raddr}, {30'd0, 2'b10, 32'h80000000});
        step();
        @(negedge clk);
        check("ifu_c2_valid", {63'd0, ifu_resp_valid}, 64'd1);
        step();
        @(negedge clk);
        check("ifu_c3_idle", {62'd0, ifu_resp_valid, mem_valid}, 64'd0);

        // LSU write
        step();
        lsu_req_valid = 1; lsu_req_addr = 32'h80001000; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEADBEEF; lsu_req_wmask = 8'h0F; lsu_resp_ready = 1;
        exp_grant.push_back(1'b1); exp_lsu.push_back(32'h0);
        @(negedge clk);
        check("wr_ready", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd1);
        step();
        lsu_req_valid = 0;
        @(negedge clk);
        check("wr_mem_ctl", {54'd0, mem_valid, mem_wen, mem_wmask}, {54'd0, 2'b11, 8'h0F});
        check("wr_mem_addr", {mem_waddr, mem_wdata}, {32'h80001000, 32'hDEADBEEF});
        step();
        @(negedge clk);
        check("wr_wen_once", {62'd0, mem_wen, lsu_resp_valid}, 64'd1);
        step();
        @(negedge clk);
        check("wr_committed", {32'd0, mem[1]}, {32'd0, 32'hDEADBEEF});

        // LSU read back
        step();
        lsu_req_valid = 1; lsu_req_wen = 0;
        exp_grant.push_back(1'b1); exp_lsu.push_back(32'hDEADBEEF);
        step();
        lsu_req_valid = 0;
        step();
        step();

        // Simultaneous requests: alternate starting with IFU (last = LSU)
        ifu_req_valid = 1; ifu_req_addr = 32'h80000000; ifu_resp_ready = 1;
        lsu_req_valid = 1; lsu_req_addr = 32'h80001000; lsu_req_wen = 0; lsu_resp_ready = 1;
        exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
        exp_ifu.push_back(32'h00000413); exp_ifu.push_back(32'h00000413);
        exp_lsu.push_back(32'hDEADBEEF); exp_lsu.push_back(32'hDEADBEEF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("rr_cycle%0d", c), {62'd0, ifu_req_ready, lsu_req_ready},
                  {62'd0, (c == 0 || c == 6), (c == 3 || c == 9)});
            step();
        end
        ifu_req_valid = 0; lsu_req_valid = 0;

        // Response backpressure on LSU with IFU waiting
        lsu_req_valid = 1; lsu_resp_ready = 0;
        exp_grant.push_back(1'b1); exp_lsu.push_back(32'hDEADBEEF);
        @(negedge clk);
        check("bp_lsu_grant", {63'd0, lsu_req_ready}, 64'd1);
        step();
        lsu_req_valid = 0; ifu_req_valid = 1;
        exp_grant.push_back(1'b0); exp_ifu.push_back(32'h00000413);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", c), {30'd0, lsu_resp_valid, ifu_req_ready, lsu_resp_rdata},
                  {30'd0, 2'b10, 32'hDEADBEEF});
            step();
        end
        lsu_resp_ready = 1;
        @(negedge clk);
        check("bp_release_no_grant", {63'd0, ifu_req_ready}, 64'd0);
        step();
        @(negedge clk);
        check("bp_next_grant", {63'd0, ifu_req_ready}, 64'd1);
        step();
        ifu_req_valid = 0;
        step();
        step();

        // Reset during ACCESS of an LSU write
        lsu_req_valid = 1; lsu_req_addr = 32'h80002000; lsu_req_wen = 1;
        lsu_req_wdata = 32'hCAFEF00D; lsu_req_wmask = 8'h0F;
        exp_grant.push_back(1'b1);
        step();
        lsu_req_valid = 0;
        #1;
        check("rst_pre_access", {62'd0, mem_valid, mem_wen}, 64'd3);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_drop_now", {62'd0, mem_valid, mem_wen}, 64'd0);
        step();
        step();
        check("rst_no_commit", {32'd0, mem[2]}, {32'd0, 32'h12345678});
        check("rst_resp_gone", {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
        resetn = 1'b1;
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_req_wen = 0;
        exp_grant.push_back(1'b0); exp_ifu.push_back(32'h00000413);
        @(negedge clk);
        check("rst_tie_ifu", {62'd0, ifu_req_ready, lsu_req_ready}, 64'd2);
        step();
        ifu_req_valid = 0; lsu_req_valid = 0;
        step();
        step();

        // Idle
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle%0d", c),
                  {ifu_resp_valid, lsu_resp_valid, mem_valid, mem_wen, mem_wmask,
                   mem_raddr | mem_waddr | mem_wdata}, 64'd0);
        end

        check("grant_q_empty", 64'(exp_grant.size()), 64'd0);
        check("ifu_q_empty", 64'(exp_ifu.size()), 64'd0);
        check("lsu_q_empty", 64'(exp_lsu.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the single-port DPI-backed physical memory model. It shares that memory between the instruction-fetch unit (read-only) and the load/store unit (read/write). Requests are granted round-robin, issued to the memory for exactly one cycle, and the result is returned over a per-requester response handshake. It sits between the core's IFU/LSU and the memory model, and is the only driver of the memory's request inputs.

## Interface
- ADDR_W, 32, address width of requests and memory
- DATA_W, 32, data width of reads and writes
- clk  in  1  system clock; all state updates on its rising edge
- resetn  in  1  asynchronous, active-low reset; deassertion is synchronised outside this block
- ifu_req_valid  in  1  IFU read request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU read data available
- ifu_resp_ready  in  1  IFU consumes the response
- ifu_resp_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request pending
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  DATA_W  write data
- lsu_req_wmask  in  8  byte write mask, forwarded unchanged
- lsu_resp_valid  out  1  LSU response available; for writes, this is the completion acknowledge
- lsu_resp_ready  in  1  LSU consumes the response
- lsu_resp_rdata  out  DATA_W  LSU read data; 0 for writes
- mem_valid  out  1  memory access enable
- mem_raddr  out  ADDR_W  memory read address
- mem_wen  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- mem_wmask  out  8  memory write mask
- mem_rdata  in  DATA_W  memory read data; combinational from mem_raddr while mem_valid=1

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, pick a winner and assert that port's req_ready combinationally for that cycle. The other port's req_ready is 0.
  - At the clock edge, latch owner, addr, wen, wdata and wmask, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration: round-robin via a 1-bit `last` register (the owner of the most recent grant).
  - A sole requester wins.
  - On a tie, the port that is not `last` wins.
  - `last` resets to LSU, so IFU wins the first tie.
  - `last` is updated at grant.
- ACCESS, exactly one cycle:
  - Drive mem_valid=1, and drive mem_raddr and mem_waddr with the latched addr.
  - Drive mem_wen = latched wen (always 0 for IFU), plus mem_wdata and mem_wmask from the latch.
  - For a read, capture mem_rdata into the response register at the edge.
  - For a write, the memory commits at that same edge and the response register loads 0.
  - Then go to RESP.
- RESP:
  - Assert the owner's resp_valid, with resp_rdata taken from the response register. The non-owner's resp_valid is 0.
  - Hold resp_valid and resp_rdata stable until the owner's resp_ready is high at an edge, then go to IDLE.
  - Both req_ready outputs are 0 in RESP and ACCESS; there is no overlapping of transactions.
- Outside ACCESS, all mem_* outputs are 0. IFU wmask and wdata are driven as 0.
- No address checking or alignment is performed; addresses pass through unchanged.

## Timing
- Reset values, all outputs:
  - req_ready: 0
  - resp_valid: 0
  - resp_rdata: 0
  - all mem_*: 0
  - state: IDLE
  - `last`: LSU
- Reset mid-transaction:
  - Assertion immediately forces IDLE and zeroes all outputs.
  - If reset is asserted during ACCESS before the edge, mem_valid and mem_wen drop at once, so no write is committed.
  - Pending responses are discarded.
- Latency: request accepted at edge N (end of IDLE cycle), memory access in cycle N+1, resp_valid from cycle N+2.
- Minimum 3 cycles per transaction, including the IDLE cycle. Peak throughput is 1 transaction per 3 cycles.
- req_valid deasserted in IDLE before any edge: no grant, no side effect.
- Requester behaviour: requesters hold req_valid and payload until req_ready. The arbiter is not required to tolerate payload changes within the grant cycle.
- resp_ready asserted early (in ACCESS) has no effect; only RESP-state edges count.

## Test plan
- IFU read alone: ifu_req_valid=1, addr=0x80000000, memory holds 0x00000413.
  - ifu_req_ready=1 in cycle 0.
  - mem_valid=1, mem_wen=0, mem_raddr=0x80000000 in cycle 1.
  - ifu_resp_valid=1, rdata=0x00000413 in cycle 2.
  - Back in IDLE in cycle 3 (resp_ready held 1).
- LSU write then read: write addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F.
  - mem_wen=1 for exactly one cycle, with those values.
  - lsu_resp_valid=1 with rdata=0.
  - Subsequent LSU read of 0x80001000 returns 0xDEADBEEF.
- Simultaneous requests, both held valid for 4 transactions: grants alternate IFU, LSU, IFU, LSU.
  - The non-granted port's req_ready is never 1 while the other port owns the memory.
- Response backpressure: lsu_resp_ready=0 for 5 cycles in RESP.
  - lsu_resp_valid and rdata stay stable.
  - No new grant is issued to a waiting IFU until the cycle after lsu_resp_ready=1.
- Reset during ACCESS of an LSU write: resetn=0 mid-cycle.
  - mem_valid and mem_wen go 0 immediately.
  - Memory contents are unchanged.
  - After release, the first tie is granted to IFU.
- Idle: no requests for 10 cycles → all mem_* = 0, both resp_valid = 0.
